// File: rtl/vga_text_ctrl.sv
// vga_text_ctrl: bus-side VGA text-mode device.
//   Bus side : four-phase request/ACK handshake on vga_ctrl/vga_stat for cell
//              writes and reads into a COLS x ROWS buffer of 16-bit cells
//              ({attr, char}).
//   Scan side: 640x480 style raster timing. Each pixel tick presents the cell
//              under the beam plus the glyph coordinates for the font stage.
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   vga_ctrl  [31:0]    request pins at `VGA_WRITE_PIN / `VGA_READ_PIN
//   vga_stat  [31:0]    ACK at `VGA_ACK, all other bits zero
//   addr      [31:0]    cell index row*COLS+col
//   data_in   [31:0]    write data, [15:0] stored
//   data_out  [31:0]    read data {16'h0, cell}, valid while ACK on a read
//   vga_hs, vga_vs      active-low syncs
//   vga_de              active-area enable
//   cell_char/cell_attr current cell, zero when blank
//   glyph_row/glyph_col y mod CHAR_H, x mod CHAR_W
// Optional feature: define VGA_CURSOR_EN for a blinking cursor at index
// register address 32'hFFFF (attribute nibbles swapped while blink is on).

`ifndef VGA_WRITE_PIN
`define VGA_WRITE_PIN 0
`endif
`ifndef VGA_READ_PIN
`define VGA_READ_PIN 1
`endif
`ifndef VGA_ACK
`define VGA_ACK 0
`endif

module vga_text_ctrl #(
  parameter int COLS    = 80,
  parameter int ROWS    = 25,
  parameter int CHAR_W  = 8,
  parameter int CHAR_H  = 16,
  parameter int PIX_DIV = 2,
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] vga_ctrl,
  output logic [31:0] vga_stat,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [7:0]  cell_char,
  output logic [7:0]  cell_attr,
  output logic [3:0]  glyph_row,
  output logic [2:0]  glyph_col
);

  localparam int CELLS = COLS * ROWS;
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int XW    = $clog2(H_TOT);
  localparam int YW    = $clog2(V_TOT);
  localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int DW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(H_TOT - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(H_ACT);
  localparam logic [XW-1:0] X_TXT  = XW'(COLS * CHAR_W);
  localparam logic [XW-1:0] X_HS0  = XW'(H_ACT + H_FP);
  localparam logic [XW-1:0] X_HS1  = XW'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOT - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(V_ACT);
  localparam logic [YW-1:0] Y_TXT  = YW'(ROWS * CHAR_H);
  localparam logic [YW-1:0] Y_VS0  = YW'(V_ACT + V_FP);
  localparam logic [YW-1:0] Y_VS1  = YW'(V_ACT + V_FP + V_SYNC - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_GRANT = 2'd1,
    BUS_ACK   = 2'd2
  } bus_state_t;

  logic [15:0]   mem [CELLS];
  bus_state_t    bus_state;
  logic          ack_r;
  logic          wr_req_s;
  logic          rd_req_s;
  logic          addr_ok_s;
  logic          mem_we_s;
  logic [AW-1:0] bus_idx_s;
  logic [15:0]   rd_data_s;
  logic          unused_bits_s;

  logic [DW-1:0] div_r;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic          pix_en_s;
  logic          de_s;
  logic          txt_s;
  logic          hs_s;
  logic          vs_s;
  logic [AW-1:0] scan_idx_s;
  logic [15:0]   scan_word_s;
  logic [7:0]    attr_s;

`ifdef VGA_CURSOR_EN
  localparam logic [31:0] CURSOR_ADDR = 32'h0000_FFFF;
  logic [15:0] cursor_r;
  logic [4:0]  blink_cnt_r;
  logic        blink_on_r;
  logic        cursor_hit_s;
`endif

  // Bus request decode; WRITE wins over READ when both are raised.
  always_comb begin
    wr_req_s      = vga_ctrl[`VGA_WRITE_PIN];
    rd_req_s      = vga_ctrl[`VGA_READ_PIN];
    addr_ok_s     = (addr < 32'(CELLS));
    bus_idx_s     = addr_ok_s ? AW'(addr) : {AW{1'b0}};
    mem_we_s      = (bus_state == BUS_IDLE) && wr_req_s && addr_ok_s && !rst;
    unused_bits_s = ^{vga_ctrl, data_in[31:16]};
  end

  // Bus read data mux: buffer cell, cursor register, or zero.
  always_comb begin
    rd_data_s = 16'h0000;
    if (addr_ok_s) begin
      rd_data_s = mem[bus_idx_s];
`ifdef VGA_CURSOR_EN
    end else if (addr == CURSOR_ADDR) begin
      rd_data_s = cursor_r;
`endif
    end else begin
      rd_data_s = 16'h0000;
    end
  end

  // ACK is a plain register bit; every other status bit reads zero.
  always_comb begin
    vga_stat             = 32'h0000_0000;
    vga_stat[`VGA_ACK]   = ack_r;
  end

  // Bus handshake FSM. GRANT gives the one-cycle gap between accepting a
  // request and raising ACK; ACK holds until both pins are seen low.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_state <= BUS_IDLE;
      ack_r     <= 1'b0;
      data_out  <= 32'h0000_0000;
`ifdef VGA_CURSOR_EN
      cursor_r  <= 16'hFFFF;
`endif
    end else begin
      case (bus_state)
        BUS_IDLE: begin
          ack_r <= 1'b0;
          if (wr_req_s) begin
            bus_state <= BUS_GRANT;
`ifdef VGA_CURSOR_EN
            if (addr == CURSOR_ADDR) begin
              cursor_r <= data_in[15:0];
            end
`endif
          end else if (rd_req_s) begin
            bus_state <= BUS_GRANT;
            data_out  <= {16'h0000, rd_data_s};
          end else begin
            bus_state <= BUS_IDLE;
          end
        end
        BUS_GRANT: begin
          ack_r     <= 1'b1;
          bus_state <= BUS_ACK;
        end
        BUS_ACK: begin
          if (!wr_req_s && !rd_req_s) begin
            ack_r     <= 1'b0;
            bus_state <= BUS_IDLE;
          end else begin
            ack_r     <= 1'b1;
          end
        end
        default: begin
          ack_r     <= 1'b0;
          bus_state <= BUS_IDLE;
        end
      endcase
    end
  end

  // Bus write port of the cell buffer; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[bus_idx_s] <= data_in[15:0];
    end
  end

  // Raster decode for the current beam position and the scan-port read.
  always_comb begin
    pix_en_s    = (div_r == DIV_LAST);
    de_s        = (x_r < X_ACT) && (y_r < Y_ACT);
    txt_s       = de_s && (y_r < Y_TXT) && (x_r < X_TXT);
    hs_s        = !((x_r >= X_HS0) && (x_r <= X_HS1));
    vs_s        = !((y_r >= Y_VS0) && (y_r <= Y_VS1));
    scan_idx_s  = txt_s ? AW'((int'(y_r) / CHAR_H) * COLS + int'(x_r) / CHAR_W)
                        : {AW{1'b0}};
    scan_word_s = mem[scan_idx_s];
`ifdef VGA_CURSOR_EN
    cursor_hit_s = blink_on_r && txt_s && (16'(scan_idx_s) == cursor_r);
    if (cursor_hit_s) begin
      attr_s = {scan_word_s[11:8], scan_word_s[15:12]};
    end else begin
      attr_s = scan_word_s[15:8];
    end
`else
    attr_s = scan_word_s[15:8];
`endif
  end

  // Pixel divider and beam position counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r <= {DW{1'b0}};
      x_r   <= {XW{1'b0}};
      y_r   <= {YW{1'b0}};
    end else if (pix_en_s) begin
      div_r <= {DW{1'b0}};
      if (x_r == X_LAST) begin
        x_r <= {XW{1'b0}};
        y_r <= (y_r == Y_LAST) ? {YW{1'b0}} : y_r + {{(YW-1){1'b0}}, 1'b1};
      end else begin
        x_r <= x_r + {{(XW-1){1'b0}}, 1'b1};
      end
    end else begin
      div_r <= div_r + {{(DW-1){1'b0}}, 1'b1};
    end
  end

  // Output stage: syncs and glyph coordinates are registered on the same
  // pixel tick as the cell fetch, so everything leaves aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hs    <= 1'b1;
      vga_vs    <= 1'b1;
      vga_de    <= 1'b0;
      cell_char <= 8'h00;
      cell_attr <= 8'h00;
      glyph_row <= 4'h0;
      glyph_col <= 3'h0;
    end else if (pix_en_s) begin
      vga_hs    <= hs_s;
      vga_vs    <= vs_s;
      vga_de    <= de_s;
      cell_char <= txt_s ? scan_word_s[7:0] : 8'h00;
      cell_attr <= txt_s ? attr_s : 8'h00;
      glyph_row <= 4'(int'(y_r) % CHAR_H);
      glyph_col <= 3'(int'(x_r) % CHAR_W);
    end else begin
      vga_hs    <= vga_hs;
      vga_vs    <= vga_vs;
      vga_de    <= vga_de;
      cell_char <= cell_char;
      cell_attr <= cell_attr;
      glyph_row <= glyph_row;
      glyph_col <= glyph_col;
    end
  end

`ifdef VGA_CURSOR_EN
  // Blink phase flips once every 32 frames, counted at the frame wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_r <= 5'd0;
      blink_on_r  <= 1'b0;
    end else if (pix_en_s && (x_r == X_LAST) && (y_r == Y_LAST)) begin
      blink_cnt_r <= blink_cnt_r + 5'd1;
      if (blink_cnt_r == 5'd31) begin
        blink_on_r <= !blink_on_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Self-checking bench for vga_text_ctrl. A reduced vertical geometry keeps a
// whole frame short; the horizontal timing is the standard 800-pixel line.
`timescale 1ns/1ps

`ifndef VGA_WRITE_PIN
`define VGA_WRITE_PIN 0
`endif
`ifndef VGA_READ_PIN
`define VGA_READ_PIN 1
`endif
`ifndef VGA_ACK
`define VGA_ACK 0
`endif

module tb_vga_text_ctrl;
  localparam int COLS = 80, ROWS = 2, CHAR_W = 8, CHAR_H = 16, PIX_DIV = 1;
  localparam int H_ACT = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam int V_ACT = 36, V_FP = 2, V_SYNC = 2, V_BP = 2;
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int CELLS = COLS * ROWS;
  localparam logic [25:0] RESET_VEC = 26'h3000000;   // hs=1, vs=1, rest 0
  localparam logic [25:0] NO_CELL   = 26'h380007F;   // hides char/attr

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] vga_ctrl = 32'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] vga_stat, data_out;
  logic        vga_hs, vga_vs, vga_de;
  logic [7:0]  cell_char, cell_attr;
  logic [3:0]  glyph_row;
  logic [2:0]  glyph_col;

  int nvec = 0;
  int nmis = 0;

  vga_text_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .PIX_DIV(PIX_DIV),
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .rst(rst), .vga_ctrl(vga_ctrl), .vga_stat(vga_stat),
    .addr(addr), .data_in(data_in), .data_out(data_out),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .cell_char(cell_char), .cell_attr(cell_attr),
    .glyph_row(glyph_row), .glyph_col(glyph_col)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pixel outputs are a pure function of the linear pixel index since reset
  // and of the buffer contents; the buffer shadow is updated on the edge
  // that accepts a write (the rising edge of the sampled WRITE pin).
  logic [15:0] shadow [CELLS];
  int unsigned cyc = 0;
  logic        model_on = 1'b0;
  logic        prev_wr = 1'b0;
  logic [25:0] exp_vec = RESET_VEC;
  bit          cells_ok = 1'b0;

  function automatic logic [25:0] model_px(input int p);
    int x, y;
    bit de, txt, hs, vs;
    logic [15:0] c;
    x   = p % H_TOT;
    y   = p / H_TOT;
    de  = (x < H_ACT) && (y < V_ACT);
    txt = de && (y < ROWS * CHAR_H) && (x < COLS * CHAR_W);
    hs  = !((x >= H_ACT + H_FP) && (x < H_ACT + H_FP + H_SYNC));
    vs  = !((y >= V_ACT + V_FP) && (y < V_ACT + V_FP + V_SYNC));
    c   = txt ? shadow[(y / CHAR_H) * COLS + x / CHAR_W] : 16'h0000;
    return {hs, vs, de, c[7:0], c[15:8], 4'(y % CHAR_H), 3'(x % CHAR_W)};
  endfunction

  always @(posedge clk) begin
    prev_wr <= vga_ctrl[`VGA_WRITE_PIN];
    if (rst) begin
      model_on <= 1'b1;
      cyc      <= 0;
      exp_vec  <= RESET_VEC;
    end else begin
      if (cyc % PIX_DIV == PIX_DIV - 1)
        exp_vec <= model_px(int'((cyc / PIX_DIV) % FRAME));
      cyc <= cyc + 1;
      if (vga_ctrl[`VGA_WRITE_PIN] && !prev_wr && addr < 32'(CELLS))
        shadow[addr[7:0]] <= data_in[15:0];
    end
  end

  // Every pixel-side output compared on every falling edge.
  always @(negedge clk) begin
    if (model_on) begin
      check("pixel", cells_ok ? {vga_hs, vga_vs, vga_de, cell_char, cell_attr, glyph_row, glyph_col}
                              : ({vga_hs, vga_vs, vga_de, cell_char, cell_attr, glyph_row, glyph_col} & NO_CELL),
            cells_ok ? exp_vec : (exp_vec & NO_CELL));
    end
  end

  // One four-phase transaction with latency, hold and release checks.
  task automatic bus_xfer(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                          input bit chk_rd, input logic [31:0] exp_rd, input string nm);
    int n;
    bit got;
    logic [31:0] ack_word;
    ack_word = 32'h0;
    ack_word[`VGA_ACK] = 1'b1;
    @(negedge clk);
    vga_ctrl = 32'h0;
    vga_ctrl[`VGA_WRITE_PIN] = w;
    vga_ctrl[`VGA_READ_PIN]  = r;
    addr = a;
    data_in = d;
    n = 0;
    got = 1'b0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (vga_stat[`VGA_ACK]) got = 1'b1;
    end
    check({nm, "_ack_lat"}, got ? n : 99, 2);
    check({nm, "_stat"}, vga_stat, ack_word);
    if (chk_rd) check({nm, "_rdata"}, data_out, exp_rd);
    @(negedge clk);
    check({nm, "_ack_hold"}, vga_stat, ack_word);
    vga_ctrl = 32'h0;
    @(negedge clk);
    check({nm, "_ack_drop"}, vga_stat, 32'h0);
  endtask

  typedef struct {
    bit          w;
    bit          r;
    logic [31:0] a;
    logic [31:0] d;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [13];
  bit   cnt_done = 1'b0;

  initial begin
    int hs_low, hs_fall, vs_low, de_hi;
    logic hs_prev;

    tbl[0]  = '{1'b1, 1'b0, 32'd5,    32'h0000_0241, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'd5,    32'h0,         1'b1, 32'h0000_0241};
    tbl[2]  = '{1'b1, 1'b0, 32'd2000, 32'h0000_1234, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 32'd2000, 32'h0,         1'b1, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 32'd7,    32'h0000_0307, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 32'd7,    32'h0,         1'b1, 32'h0000_0307};
    tbl[6]  = '{1'b1, 1'b0, 32'd81,   32'h0000_0741, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 1'b1, 32'd81,   32'h0,         1'b1, 32'h0000_0741};
    tbl[8]  = '{1'b1, 1'b0, 32'd160,  32'h0000_BEEF, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 32'd160,  32'h0,         1'b1, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'd159,  32'hFFFF_A5C3, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 32'd159,  32'h0,         1'b1, 32'h0000_A5C3};
`ifdef VGA_CURSOR_EN
    tbl[12] = '{1'b0, 1'b1, 32'hFFFF, 32'h0,         1'b1, 32'h0000_FFFF};
`else
    tbl[12] = '{1'b0, 1'b1, 32'hFFFF, 32'h0,         1'b1, 32'h0};
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_stat", vga_stat, 32'h0);
    check("reset_dout", data_out, 32'h0);

    // Fill the whole buffer so every scanned cell has a known value.
    for (int i = 0; i < CELLS; i++)
      bus_xfer(1'b1, 1'b0, 32'(i), $urandom, 1'b0, 32'h0, "fill");
    cells_ok = 1'b1;

    for (int i = 0; i < 13; i++)
      bus_xfer(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].chk, tbl[i].exp, $sformatf("vec%0d", i));

    // Reset while ACK is high: ACK and syncs must return to idle at once.
    @(negedge clk);
    vga_ctrl = 32'h0;
    vga_ctrl[`VGA_WRITE_PIN] = 1'b1;
    addr = 32'd3;
    data_in = 32'h0000_1E33;
    repeat (2) @(negedge clk);
    check("pre_rst_ack", {31'h0, vga_stat[`VGA_ACK]}, 32'h1);
    rst = 1'b1;
    vga_ctrl = 32'h0;
    @(negedge clk);
    check("rst_ack", vga_stat, 32'h0);
    check("rst_sync", {vga_hs, vga_vs, vga_de}, 3'b110);
    rst = 1'b0;
    bus_xfer(1'b0, 1'b1, 32'd3, 32'h0, 1'b1, 32'h0000_1E33, "rst_wr_kept");
`ifdef VGA_CURSOR_EN
    bus_xfer(1'b0, 1'b1, 32'hFFFF, 32'h0, 1'b1, 32'h0000_FFFF, "rst_cursor");
`endif

    // One full frame of timing statistics alongside random bus traffic.
    hs_prev = vga_hs;
    hs_low = 0; hs_fall = 0; vs_low = 0; de_hi = 0;
    fork
      begin
        for (int i = 0; i < FRAME * PIX_DIV; i++) begin
          @(negedge clk);
          if (!vga_hs) hs_low++;
          if (hs_prev && !vga_hs) hs_fall++;
          if (!vga_vs) vs_low++;
          if (vga_de) de_hi++;
          hs_prev = vga_hs;
        end
        cnt_done = 1'b1;
      end
      begin
        while (!cnt_done) begin
          logic [31:0] ra;
          ra = $urandom_range(CELLS + 7, 0);
          if ($urandom_range(1, 0) == 1)
            bus_xfer(1'b1, 1'($urandom_range(1, 0)), ra, $urandom, 1'b0, 32'h0, "rnd_wr");
          else
            bus_xfer(1'b0, 1'b1, ra, 32'h0, 1'b1,
                     (ra < 32'(CELLS)) ? {16'h0, shadow[ra[7:0]]} : 32'h0, "rnd_rd");
          repeat ($urandom_range(3, 0)) @(negedge clk);
        end
      end
    join

    check("hs_low_clks", hs_low, H_SYNC * V_TOT * PIX_DIV);
    check("hs_periods", hs_fall, V_TOT);
    check("vs_low_clks", vs_low, V_SYNC * H_TOT * PIX_DIV);
    check("de_clks", de_hi, H_ACT * V_ACT * PIX_DIV);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
